// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage pipeline.
// Issues aligned loads and stores on a single-master cyc/ack/err data port.
// Generates byte lanes and extracts/extends load data. Catches misaligned
// and bus-error faults and registers the result into the MEM/WB register.
//
// Data-port handshake: a request is valid while dport_cyc_o is high. Address,
// data, lanes and we stay stable until the cycle in which dport_ack_i or
// dport_err_i is sampled high; err wins over ack. cyc then drops for at least
// one cycle (DONE) before the next request can be raised.
module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_stall_i,
    input  logic        mem_flush_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_store_data_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [5:0]  mem_mem_flags_i,
    input  logic        mem_mem_ex_sel_i,
    output logic [31:0] dport_addr_o,
    output logic [31:0] dport_dat_o,
    output logic [3:0]  dport_sel_o,
    output logic        dport_we_o,
    output logic        dport_cyc_o,
    input  logic [31:0] dport_dat_i,
    input  logic        dport_ack_i,
    input  logic        dport_err_i,
    output logic [31:0] mem_fwd_dat_o,
    output logic        mem_request_stall_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_wdata_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic        wb_exc_load_o,
    output logic        wb_exc_store_o,
    output logic        wb_exc_bus_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;

    // Operation decode; read wins when both read and write are set
    logic        op_read;
    logic        op_write;
    logic        op_any;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        issue;
    logic        done_kill;

    // Instruction context held while the bus cycle is outstanding
    logic [31:0] pc_q;
    logic [31:0] result_q;
    logic [4:0]  waddr_q;
    logic        we_q;
    logic        ex_sel_q;
    logic        byte_q;
    logic        half_q;
    logic        sext_q;
    logic        err_q;
    logic        flush_q;
    logic [31:0] load_q;

    logic [3:0]  lane_sel;
    logic [31:0] store_dat;
    logic [31:0] load_shift;
    logic [31:0] load_ext;
    logic        unused_flag;

    assign op_read    = mem_mem_flags_i[0];
    assign op_write   = mem_mem_flags_i[1] & ~mem_mem_flags_i[0];
    assign op_any     = mem_mem_flags_i[0] | mem_mem_flags_i[1];
    assign is_byte    = mem_mem_flags_i[2];
    assign is_half    = ~mem_mem_flags_i[2] & mem_mem_flags_i[3];
    assign is_word    = ~mem_mem_flags_i[2] & ~mem_mem_flags_i[3];
    assign misaligned = (is_half & mem_result_i[0]) | (is_word & (|mem_result_i[1:0]));
    assign issue      = (state == IDLE) & op_any & ~misaligned & ~mem_flush_i;
    assign done_kill  = flush_q | mem_flush_i;
    assign unused_flag = mem_mem_flags_i[5];

    assign mem_request_stall_o = issue | (state == BUSY);
    assign mem_fwd_dat_o       = mem_result_i;
    assign dbg_state_o         = state;

    // Byte-lane enables and lane-replicated store data for the request
    always_comb begin
        lane_sel  = 4'hF;
        store_dat = mem_store_data_i;
        if (is_byte) begin
            lane_sel  = 4'b0001 << mem_result_i[1:0];
            store_dat = {4{mem_store_data_i[7:0]}};
        end else if (is_half) begin
            lane_sel  = 4'b0011 << mem_result_i[1:0];
            store_dat = {2{mem_store_data_i[15:0]}};
        end
    end

    // Align returned read data to bit 0 and extend to 32 bits
    always_comb begin
        load_shift = dport_dat_i >> {result_q[1:0], 3'b000};
        load_ext   = load_shift;
        if (byte_q) begin
            load_ext = {{24{sext_q & load_shift[7]}}, load_shift[7:0]};
        end else if (half_q) begin
            load_ext = {{16{sext_q & load_shift[15]}}, load_shift[15:0]};
        end
    end

    // Stage FSM: bus sequencing and MEM/WB register update
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            dport_addr_o   <= '0;
            dport_dat_o    <= '0;
            dport_sel_o    <= '0;
            dport_we_o     <= 1'b0;
            dport_cyc_o    <= 1'b0;
            wb_pc_o        <= '0;
            wb_wdata_o     <= '0;
            wb_waddr_o     <= '0;
            wb_we_o        <= 1'b0;
            wb_exc_load_o  <= 1'b0;
            wb_exc_store_o <= 1'b0;
            wb_exc_bus_o   <= 1'b0;
            pc_q           <= '0;
            result_q       <= '0;
            waddr_q        <= '0;
            we_q           <= 1'b0;
            ex_sel_q       <= 1'b0;
            byte_q         <= 1'b0;
            half_q         <= 1'b0;
            sext_q         <= 1'b0;
            err_q          <= 1'b0;
            flush_q        <= 1'b0;
            load_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        dport_addr_o <= {mem_result_i[31:2], 2'b00};
                        dport_dat_o  <= store_dat;
                        dport_sel_o  <= lane_sel;
                        dport_we_o   <= op_write;
                        dport_cyc_o  <= 1'b1;
                        pc_q         <= mem_pc_i;
                        result_q     <= mem_result_i;
                        waddr_q      <= mem_waddr_i;
                        we_q         <= mem_we_i;
                        ex_sel_q     <= mem_mem_ex_sel_i;
                        byte_q       <= is_byte;
                        half_q       <= is_half;
                        sext_q       <= mem_mem_flags_i[4];
                        err_q        <= 1'b0;
                        flush_q      <= 1'b0;
                        state        <= BUSY;
                    end else if (!mem_stall_i) begin
                        // Non-memory op, misaligned fault or flushed bubble
                        wb_pc_o        <= mem_pc_i;
                        wb_wdata_o     <= mem_result_i;
                        wb_waddr_o     <= mem_waddr_i;
                        wb_we_o        <= mem_we_i & ~op_any & ~mem_flush_i;
                        wb_exc_load_o  <= op_read & misaligned & ~mem_flush_i;
                        wb_exc_store_o <= op_write & misaligned & ~mem_flush_i;
                        wb_exc_bus_o   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_flush_i) begin
                        flush_q <= 1'b1;
                    end
                    if (dport_err_i) begin
                        err_q       <= 1'b1;
                        dport_cyc_o <= 1'b0;
                        state       <= DONE;
                    end else if (dport_ack_i) begin
                        load_q      <= load_ext;
                        dport_cyc_o <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (!mem_stall_i) begin
                        wb_pc_o        <= pc_q;
                        wb_wdata_o     <= ex_sel_q ? load_q : result_q;
                        wb_waddr_o     <= waddr_q;
                        wb_we_o        <= we_q & ~err_q & ~done_kill;
                        wb_exc_load_o  <= 1'b0;
                        wb_exc_store_o <= 1'b0;
                        wb_exc_bus_o   <= err_q & ~done_kill;
                        flush_q        <= 1'b0;
                        state          <= IDLE;
                    end else if (mem_flush_i) begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    dport_cyc_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage with a behavioural model of
// the expected bus request and MEM/WB results.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        mem_flush_i = 1'b0;
    logic [31:0] mem_pc_i = '0;
    logic [31:0] mem_result_i = '0;
    logic [31:0] mem_store_data_i = '0;
    logic [4:0]  mem_waddr_i = '0;
    logic        mem_we_i = 1'b0;
    logic [5:0]  mem_mem_flags_i = '0;
    logic        mem_mem_ex_sel_i = 1'b0;
    logic [31:0] dport_addr_o;
    logic [31:0] dport_dat_o;
    logic [3:0]  dport_sel_o;
    logic        dport_we_o;
    logic        dport_cyc_o;
    logic [31:0] dport_dat_i = '0;
    logic        dport_ack_i = 1'b0;
    logic        dport_err_i = 1'b0;
    logic [31:0] mem_fwd_dat_o;
    logic        mem_request_stall_o;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_wdata_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o;
    logic        wb_exc_load_o;
    logic        wb_exc_store_o;
    logic        wb_exc_bus_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int failures = 0;

    // Expected MEM/WB contents
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_wdata = '0;
    logic [4:0]  exp_waddr = '0;
    logic        exp_we = 1'b0;
    logic        exp_el = 1'b0;
    logic        exp_es = 1'b0;
    logic        exp_eb = 1'b0;

    mem_stage dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .mem_stall_i         (mem_stall_i),
        .mem_flush_i         (mem_flush_i),
        .mem_pc_i            (mem_pc_i),
        .mem_result_i        (mem_result_i),
        .mem_store_data_i    (mem_store_data_i),
        .mem_waddr_i         (mem_waddr_i),
        .mem_we_i            (mem_we_i),
        .mem_mem_flags_i     (mem_mem_flags_i),
        .mem_mem_ex_sel_i    (mem_mem_ex_sel_i),
        .dport_addr_o        (dport_addr_o),
        .dport_dat_o         (dport_dat_o),
        .dport_sel_o         (dport_sel_o),
        .dport_we_o          (dport_we_o),
        .dport_cyc_o         (dport_cyc_o),
        .dport_dat_i         (dport_dat_i),
        .dport_ack_i         (dport_ack_i),
        .dport_err_i         (dport_err_i),
        .mem_fwd_dat_o       (mem_fwd_dat_o),
        .mem_request_stall_o (mem_request_stall_o),
        .wb_pc_o             (wb_pc_o),
        .wb_wdata_o          (wb_wdata_o),
        .wb_waddr_o          (wb_waddr_o),
        .wb_we_o             (wb_we_o),
        .wb_exc_load_o       (wb_exc_load_o),
        .wb_exc_store_o      (wb_exc_store_o),
        .wb_exc_bus_o        (wb_exc_bus_o),
        .dbg_state_o         (dbg_state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Reference model: access size in bytes
    function automatic int size_of(input logic [5:0] f);
        if (f[2]) return 1;
        if (f[3]) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_sel(input logic [5:0] f, input logic [31:0] a);
        int m;
        m = ((1 << size_of(f)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_store(input logic [5:0] f, input logic [31:0] d);
        if (size_of(f) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size_of(f) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (size_of(f) == 1) begin
            v = v & 32'hFF;
            if (f[4] && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (size_of(f) == 2) begin
            v = v & 32'hFFFF;
            if (f[4] && v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic check_wb(input string tag, input bit full);
        chk({tag, ".wb_we"}, 32'(wb_we_o), 32'(exp_we));
        chk({tag, ".exc_load"}, 32'(wb_exc_load_o), 32'(exp_el));
        chk({tag, ".exc_store"}, 32'(wb_exc_store_o), 32'(exp_es));
        chk({tag, ".exc_bus"}, 32'(wb_exc_bus_o), 32'(exp_eb));
        if (full) begin
            chk({tag, ".wb_pc"}, wb_pc_o, exp_pc);
            chk({tag, ".wb_wdata"}, wb_wdata_o, exp_wdata);
            chk({tag, ".wb_waddr"}, 32'(wb_waddr_o), 32'(exp_waddr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".dport_addr"}, dport_addr_o, 32'h0);
        chk({tag, ".dport_dat"}, dport_dat_o, 32'h0);
        chk({tag, ".dport_sel"}, 32'(dport_sel_o), 32'h0);
        chk({tag, ".dport_we"}, 32'(dport_we_o), 32'h0);
        chk({tag, ".dport_cyc"}, 32'(dport_cyc_o), 32'h0);
        exp_pc = '0; exp_wdata = '0; exp_waddr = '0;
        exp_we = 1'b0; exp_el = 1'b0; exp_es = 1'b0; exp_eb = 1'b0;
        check_wb(tag, 1'b1);
    endtask

    // Present one instruction to the stage and follow it into MEM/WB.
    // Entered and left just after a falling edge.
    task automatic run_instr(input string tag, input logic [5:0] flags, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] pc,
                             input logic [4:0] waddr, input logic we, input logic ex_sel,
                             input int waits, input bit err, input logic [31:0] rdata,
                             input bit flush_busy, input int done_stall);
        bit rd, wr, op, misal, bus;
        int sz, stall_cnt;
        logic [31:0] prev_pc;
        rd = flags[0];
        wr = flags[1] && !flags[0];
        op = flags[0] || flags[1];
        sz = size_of(flags);
        misal = (addr % sz) != 0;
        bus = op && !misal;

        mem_pc_i = pc; mem_result_i = addr; mem_store_data_i = sdata;
        mem_waddr_i = waddr; mem_we_i = we; mem_mem_flags_i = flags;
        mem_mem_ex_sel_i = ex_sel; mem_flush_i = 1'b0; mem_stall_i = 1'b0;
        dport_ack_i = 1'b0; dport_err_i = 1'b0;
        #1;
        chk({tag, ".stall_req"}, 32'(mem_request_stall_o), 32'(bus));
        chk({tag, ".fwd"}, mem_fwd_dat_o, addr);

        if (!bus) begin
            tick;
            chk({tag, ".no_cyc"}, 32'(dport_cyc_o), 32'h0);
            exp_pc = pc; exp_wdata = addr; exp_waddr = waddr;
            exp_we = we && !op;
            exp_el = op && rd && misal;
            exp_es = op && wr && misal;
            exp_eb = 1'b0;
            check_wb(tag, 1'b1);
        end else begin
            prev_pc = exp_pc;
            stall_cnt = 1;
            tick;
            chk({tag, ".cyc"}, 32'(dport_cyc_o), 32'h1);
            chk({tag, ".addr"}, dport_addr_o, {addr[31:2], 2'b00});
            chk({tag, ".sel"}, 32'(dport_sel_o), 32'(model_sel(flags, addr)));
            chk({tag, ".we"}, 32'(dport_we_o), 32'(wr));
            if (wr) chk({tag, ".dat"}, dport_dat_o, model_store(flags, sdata));
            if (flush_busy) mem_flush_i = 1'b1;
            for (int w = 0; w < waits; w++) begin
                stall_cnt += int'(mem_request_stall_o);
                tick;
                mem_flush_i = 1'b0;
                chk({tag, ".cyc_hold"}, 32'(dport_cyc_o), 32'h1);
                chk({tag, ".addr_hold"}, dport_addr_o, {addr[31:2], 2'b00});
            end
            stall_cnt += int'(mem_request_stall_o);
            dport_dat_i = rdata;
            dport_ack_i = 1'b1;
            dport_err_i = err;
            tick;
            dport_ack_i = 1'b0; dport_err_i = 1'b0; mem_flush_i = 1'b0;
            dport_dat_i = $urandom;
            #1;
            chk({tag, ".cyc_drop"}, 32'(dport_cyc_o), 32'h0);
            chk({tag, ".stall_done"}, 32'(mem_request_stall_o), 32'h0);
            chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(waits + 2));
            chk({tag, ".wb_not_yet"}, wb_pc_o, prev_pc);
            mem_stall_i = 1'b1;
            for (int s = 0; s < done_stall; s++) begin
                tick;
                chk({tag, ".done_hold"}, wb_pc_o, prev_pc);
                chk({tag, ".done_no_cyc"}, 32'(dport_cyc_o), 32'h0);
            end
            mem_stall_i = 1'b0;
            tick;
            exp_pc = pc; exp_waddr = waddr;
            exp_wdata = ex_sel ? model_load(flags, addr, rdata) : addr;
            exp_we = we && !err && !flush_busy;
            exp_el = 1'b0; exp_es = 1'b0;
            exp_eb = err && !flush_busy;
            check_wb(tag, !err && !flush_busy);
        end
    endtask

    initial begin
        logic [31:0] prev_pc;
        // Reset: outputs zero, stall request follows inputs
        rst_i = 1'b0;
        mem_mem_flags_i = 6'b000001;
        mem_result_i = 32'h0000_0040;
        #1;
        check_all_zero("reset");
        chk("reset.stall_follows", 32'(mem_request_stall_o), 32'h1);
        mem_mem_flags_i = 6'b000000;
        #1;
        chk("reset.stall_idle", 32'(mem_request_stall_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Directed steps
        run_instr("lbu", 6'b000101, 32'h1003, 32'h0, 32'h100, 5'd1, 1'b1, 1'b1,
                  0, 1'b0, 32'h80FF_0000, 1'b0, 0);
        run_instr("lh_sext", 6'b011001, 32'h2002, 32'h0, 32'h104, 5'd2, 1'b1, 1'b1,
                  2, 1'b0, 32'h8001_1234, 1'b0, 0);
        run_instr("sb", 6'b000110, 32'h0001, 32'h0000_00AB, 32'h108, 5'd0, 1'b0, 1'b0,
                  0, 1'b0, 32'h0, 1'b0, 0);
        run_instr("lw_misal", 6'b000001, 32'h0006, 32'h0, 32'h10C, 5'd3, 1'b1, 1'b1,
                  0, 1'b0, 32'h0, 1'b0, 0);
        run_instr("sw_misal", 6'b000010, 32'h1_0002, 32'h1234, 32'h110, 5'd0, 1'b0, 1'b0,
                  0, 1'b0, 32'h0, 1'b0, 0);
        run_instr("sh_misal", 6'b001010, 32'h0003, 32'h1234, 32'h114, 5'd0, 1'b0, 1'b0,
                  0, 1'b0, 32'h0, 1'b0, 0);
        run_instr("lw_err", 6'b000001, 32'h0080, 32'h0, 32'h118, 5'd4, 1'b1, 1'b1,
                  1, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
        run_instr("lw_flush_busy", 6'b000001, 32'h0084, 32'h0, 32'h11C, 5'd5, 1'b1, 1'b1,
                  1, 1'b0, 32'h1111_2222, 1'b1, 1);
        run_instr("rw_as_read", 6'b000011, 32'h0044, 32'h5555, 32'h120, 5'd6, 1'b1, 1'b1,
                  0, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
        run_instr("lb_sext", 6'b010101, 32'h0002, 32'h0, 32'h124, 5'd7, 1'b1, 1'b1,
                  0, 1'b0, 32'h00FF_0000, 1'b0, 2);
        run_instr("sw", 6'b000010, 32'h0000_0100, 32'hA5A5_1234, 32'h128, 5'd0, 1'b0, 1'b0,
                  1, 1'b0, 32'h0, 1'b0, 0);
        run_instr("alu_flag5", 6'b100000, 32'h7777_0001, 32'h0, 32'h12C, 5'd8, 1'b1, 1'b0,
                  0, 1'b0, 32'h0, 1'b0, 0);

        // ALU op with downstream stall held three cycles
        prev_pc = exp_pc;
        mem_mem_flags_i = 6'b000000; mem_pc_i = 32'h500; mem_result_i = 32'h0000_CAFE;
        mem_waddr_i = 5'd9; mem_we_i = 1'b1; mem_mem_ex_sel_i = 1'b0; mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("alu_stall.hold_pc", wb_pc_o, prev_pc);
        end
        mem_stall_i = 1'b0;
        tick;
        exp_pc = 32'h500; exp_wdata = 32'h0000_CAFE; exp_waddr = 5'd9;
        exp_we = 1'b1; exp_el = 1'b0; exp_es = 1'b0; exp_eb = 1'b0;
        check_wb("alu_stall", 1'b1);

        // Flush in IDLE on a misaligned load: bubble, no fault, no request
        mem_mem_flags_i = 6'b000001; mem_pc_i = 32'h504; mem_result_i = 32'h0000_0101;
        mem_we_i = 1'b1; mem_flush_i = 1'b1;
        #1;
        chk("flush_idle.stall_req", 32'(mem_request_stall_o), 32'h0);
        tick;
        mem_flush_i = 1'b0;
        chk("flush_idle.no_cyc", 32'(dport_cyc_o), 32'h0);
        exp_we = 1'b0; exp_el = 1'b0; exp_es = 1'b0; exp_eb = 1'b0;
        check_wb("flush_idle", 1'b0);

        // Reset asserted while a load is outstanding
        mem_mem_flags_i = 6'b000001; mem_result_i = 32'h0000_0200; mem_pc_i = 32'h508;
        tick;
        chk("rst_busy.cyc_before", 32'(dport_cyc_o), 32'h1);
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("rst_busy");
        mem_mem_flags_i = 6'b000000;
        @(negedge clk_i);
        rst_i = 1'b1;
        run_instr("after_reset_alu", 6'b000000, 32'h0000_4321, 32'h0, 32'h600, 5'd10,
                  1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0);

        // Randomized instructions
        for (int n = 0; n < 60; n++) begin
            logic [5:0]  f;
            logic [31:0] a;
            f = '0;
            if ($urandom_range(0, 3) != 0) begin
                f[1:0] = 2'($urandom_range(1, 3));
                f[2] = 1'($urandom_range(0, 1));
                f[3] = 1'($urandom_range(0, 1));
                f[4] = 1'($urandom_range(0, 1));
            end
            f[5] = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run_instr("rand", f, a, $urandom, 32'h1000 + 32'(n * 4), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                      $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        mem_mem_flags_i = 6'b000000;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
